// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the CPU fetch port and the data (MEM-stage) port
// onto one SRAM driver transaction port. Data requests win over fetches.
// Byte/half/word accesses become a word address plus byte-lane select, and
// loads are sign- or zero-extended.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, misaligned
// accesses are refused without touching the RAM and flagged on align_exc_o.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_ce_i/if_addr_i   fetch request and byte address
//   if_data_o/if_ready_o fetched word and one-cycle completion pulse
//   mem_ce_i/we/addr/data/size/signed  data request fields
//   mem_data_o/mem_ready_o  extended load result and completion pulse
//   stall_req_o         combinational stall while any access is outstanding
//   align_exc_o         misalignment pulse alongside the ready pulse
//   ram_ce_o/we/addr/data/sel  registered request to the SRAM driver
//   ram_ready_i/ram_data_i     SRAM driver completion and read word
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        stall_req_o,
  output logic        align_exc_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_sel_o,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_data_i
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_FETCH   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_ram_ce, w_ram_ce;
  logic          r_ram_we, w_ram_we;
  logic [DW-1:0] r_ram_addr, w_ram_addr;
  logic [DW-1:0] r_ram_data, w_ram_data;
  logic [3:0]    r_ram_sel, w_ram_sel;
  logic          r_if_ready, w_if_ready;
  logic          r_mem_ready, w_mem_ready;
  logic [DW-1:0] r_if_data, w_if_data;
  logic [DW-1:0] r_mem_data, w_mem_data;
  logic          r_align, w_align;

  logic          w_mem_misalign;
  logic          w_if_misalign;
  logic [3:0]    w_st_sel;
  logic [DW-1:0] w_st_data;
  logic [7:0]    w_ld_byte;
  logic [15:0]   w_ld_half;
  logic [DW-1:0] w_ld_ext;

  // Misalignment detection (only when the check is compiled in)
`ifdef MEM_ALIGN_CHECK_EN
  assign w_mem_misalign = ((mem_size_i == 2'b01) & mem_addr_i[0]) |
                          (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00));
  assign w_if_misalign  = (if_addr_i[1:0] != 2'b00);
`else
  logic w_unused_if_lo;
  assign w_unused_if_lo = ^if_addr_i[1:0];
  assign w_mem_misalign = 1'b0;
  assign w_if_misalign  = 1'b0;
`endif

  // Store lane select and lane-replicated write data
  always_comb begin
    w_st_sel  = 4'b1111;
    w_st_data = mem_data_i;
    case (mem_size_i)
      2'b00: begin
        w_st_sel  = 4'b0001 << mem_addr_i[1:0];
        w_st_data = {4{mem_data_i[7:0]}};
      end
      2'b01: begin
        w_st_sel  = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    w_ld_half = mem_addr_i[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    case (mem_addr_i[1:0])
      2'b00:   w_ld_byte = ram_data_i[7:0];
      2'b01:   w_ld_byte = ram_data_i[15:8];
      2'b10:   w_ld_byte = ram_data_i[23:16];
      default: w_ld_byte = ram_data_i[31:24];
    endcase
    case (mem_size_i)
      2'b00:   w_ld_ext = mem_signed_i ? {{24{w_ld_byte[7]}}, w_ld_byte}
                                       : {24'd0, w_ld_byte};
      2'b01:   w_ld_ext = mem_signed_i ? {{16{w_ld_half[15]}}, w_ld_half}
                                       : {16'd0, w_ld_half};
      default: w_ld_ext = ram_data_i;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_sel   <= 4'b0000;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_if_data   <= '0;
      r_mem_data  <= '0;
      r_align     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ram_ce    <= w_ram_ce;
      r_ram_we    <= w_ram_we;
      r_ram_addr  <= w_ram_addr;
      r_ram_data  <= w_ram_data;
      r_ram_sel   <= w_ram_sel;
      r_if_ready  <= w_if_ready;
      r_mem_ready <= w_mem_ready;
      r_if_data   <= w_if_data;
      r_mem_data  <= w_mem_data;
      r_align     <= w_align;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_ram_ce    = r_ram_ce;
    w_ram_we    = r_ram_we;
    w_ram_addr  = r_ram_addr;
    w_ram_data  = r_ram_data;
    w_ram_sel   = r_ram_sel;
    w_if_ready  = 1'b0;
    w_mem_ready = 1'b0;
    w_if_data   = r_if_data;
    w_mem_data  = r_mem_data;
    w_align     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_ce_i) begin
          if (w_mem_misalign) begin
            // Refuse without a RAM transaction; report on the ready pulse
            w_state_nxt = S_RELEASE;
            w_mem_ready = 1'b1;
            w_align     = 1'b1;
            w_mem_data  = '0;
          end else begin
            w_state_nxt = S_DATA;
            w_ram_ce    = 1'b1;
            w_ram_we    = mem_we_i;
            w_ram_addr  = {mem_addr_i[31:2], 2'b00};
            w_ram_sel   = mem_we_i ? w_st_sel : 4'b1111;
            w_ram_data  = mem_we_i ? w_st_data : '0;
          end
        end else if (if_ce_i) begin
          if (w_if_misalign) begin
            w_state_nxt = S_RELEASE;
            w_if_ready  = 1'b1;
            w_align     = 1'b1;
            w_if_data   = '0;
          end else begin
            w_state_nxt = S_FETCH;
            w_ram_ce    = 1'b1;
            w_ram_we    = 1'b0;
            w_ram_addr  = {if_addr_i[31:2], 2'b00};
            w_ram_sel   = 4'b1111;
            w_ram_data  = '0;
          end
        end
      end
      S_DATA: begin
        if (!mem_ce_i) begin
          // Requester withdrew: drop the transaction silently
          w_ram_ce    = 1'b0;
          w_state_nxt = S_RELEASE;
        end else if (ram_ready_i) begin
          w_ram_ce    = 1'b0;
          w_mem_ready = 1'b1;
          w_mem_data  = mem_we_i ? '0 : w_ld_ext;
          w_state_nxt = S_RELEASE;
        end
      end
      S_FETCH: begin
        if (!if_ce_i) begin
          w_ram_ce    = 1'b0;
          w_state_nxt = S_RELEASE;
        end else if (ram_ready_i) begin
          w_ram_ce    = 1'b0;
          w_if_ready  = 1'b1;
          w_if_data   = ram_data_i;
          w_state_nxt = S_RELEASE;
        end
      end
      // One dead cycle keeps ram_ce_o low long enough to reset the driver
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign ram_ce_o    = r_ram_ce;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_data_o  = r_ram_data;
  assign ram_sel_o   = r_ram_sel;
  assign if_ready_o  = r_if_ready;
  assign mem_ready_o = r_mem_ready;
  assign if_data_o   = r_if_data;
  assign mem_data_o  = r_mem_data;
  assign align_exc_o = r_align;

  assign stall_req_o = (if_ce_i & ~r_if_ready) | (mem_ce_i & ~r_mem_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: SRAM driver model with random latency, plus a
// word-array reference memory updated from request semantics.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        stall_req_o;
  logic        align_exc_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_sel_o;
  logic        ram_ready_i;
  logic [31:0] ram_data_i;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i),
    .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
    .stall_req_o(stall_req_o), .align_exc_o(align_exc_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_sel_o(ram_sel_o),
    .ram_ready_i(ram_ready_i), .ram_data_i(ram_data_i)
  );

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AL_EN = 1'b1;
`else
  localparam bit AL_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];
  int          lat_cnt   = 0;
  int          fixed_lat = -1;
  bit          prev_ce   = 1'b0;
  bit          seen_issue = 1'b0;
  int          ce_low_cnt = 0;
  int          issue_cnt  = 0;
  logic [31:0] iss_addr, iss_data;
  logic [3:0]  iss_sel;
  logic        iss_we;

  // Reference: load result from a stored word
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a,
                                           logic [1:0] sz, logic sg);
    logic [31:0] v, mask;
    int bits, sh;
    if (sz == 2'b00) begin bits = 8;  sh = 8 * int'(a[1:0]); end
    else if (sz == 2'b01) begin bits = 16; sh = 16 * int'(a[1]); end
    else return w;
    mask = (32'd1 << bits) - 32'd1;
    v = (w >> sh) & mask;
    if (sg && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Reference: word after a store
  function automatic logic [31:0] ref_store(logic [31:0] w, logic [31:0] a,
                                            logic [1:0] sz, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b00) begin sh = 8 * int'(a[1:0]); mask = 32'hFF << sh; end
    else if (sz == 2'b01) begin sh = 16 * int'(a[1]); mask = 32'hFFFF << sh; end
    else begin sh = 0; mask = 32'hFFFF_FFFF; end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic bit ref_mis_mem(logic [31:0] a, logic [1:0] sz);
    bit m;
    m = (sz == 2'b01) ? a[0] : (sz[1] ? (a[1:0] != 2'b00) : 1'b0);
    return AL_EN & m;
  endfunction

  // One clock: sample just after the edge, then play the SRAM driver
  task automatic step();
    logic [3:0] idx;
    @(posedge clk); #1;
    if (ram_ce_o && !prev_ce) begin
      if (seen_issue) begin
        total++;
        if (ce_low_cnt < 2) begin
          bad++;
          $display("FAIL ce_gap: low cycles=%0d required>=2", ce_low_cnt);
        end
      end
      seen_issue = 1'b1;
      issue_cnt++;
      iss_addr = ram_addr_o; iss_data = ram_data_o;
      iss_sel  = ram_sel_o;  iss_we   = ram_we_o;
      lat_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
    end
    ce_low_cnt = ram_ce_o ? 0 : ce_low_cnt + 1;
    prev_ce    = ram_ce_o;
    if (ram_ce_o) begin
      if (lat_cnt == 0) begin
        if (!ram_ready_i) begin
          idx = ram_addr_o[5:2];
          ram_data_i = ram_mem[idx];
          if (ram_we_o)
            for (int i = 0; i < 4; i++)
              if (ram_sel_o[i]) ram_mem[idx][8*i +: 8] = ram_data_o[8*i +: 8];
        end
        ram_ready_i = 1'b1;
      end else begin
        lat_cnt--;
        ram_ready_i = 1'b0;
      end
    end else begin
      ram_ready_i = 1'b0;
      ram_data_i  = $urandom();
    end
  endtask

  // Issue a fetch and/or data request and check each completion
  task automatic run_req(input bit do_if, input logic [31:0] ia,
                         input bit do_mem, input logic we, input logic [31:0] ma,
                         input logic [1:0] sz, input logic sg, input logic [31:0] md,
                         input bit chk_stall, input string tag, output int mem_cyc);
    bit if_done, mem_done, mis;
    logic [31:0] exp;
    int n;
    if_addr_i = ia; mem_we_i = we; mem_addr_i = ma; mem_size_i = sz;
    mem_signed_i = sg; mem_data_i = md;
    if_ce_i = do_if; mem_ce_i = do_mem;
    if_done = !do_if; mem_done = !do_mem; n = 0; mem_cyc = 0;
    while (!(if_done && mem_done) && n < 60) begin
      step(); n++;
      if (chk_stall && !if_done) begin
        total++;
        if (stall_req_o !== !if_ready_o) begin
          bad++;
          $display("FAIL %s stall: got %b want %b", tag, stall_req_o, !if_ready_o);
        end
      end
      if (mem_ce_i && mem_ready_o) begin
        mis = ref_mis_mem(ma, sz);
        if (we) begin
          exp = 32'd0;
          if (!mis) ref_mem[ma[5:2]] = ref_store(ref_mem[ma[5:2]], ma, sz, md);
        end else begin
          exp = mis ? 32'd0 : ref_load(ref_mem[ma[5:2]], ma, sz, sg);
        end
        total++;
        if (mem_data_o !== exp || align_exc_o !== mis) begin
          bad++;
          $display("FAIL %s mem: got data=%h exc=%b want data=%h exc=%b",
                   tag, mem_data_o, align_exc_o, exp, mis);
        end
        mem_done = 1'b1; mem_ce_i = 1'b0; mem_cyc = n;
      end
      if (if_ce_i && if_ready_o) begin
        mis = AL_EN & (ia[1:0] != 2'b00);
        exp = mis ? 32'd0 : ref_mem[ia[5:2]];
        total++;
        if (if_data_o !== exp || align_exc_o !== mis || !mem_done) begin
          bad++;
          $display("FAIL %s fetch: got data=%h exc=%b mem_first=%b want data=%h exc=%b mem_first=1",
                   tag, if_data_o, align_exc_o, mem_done, exp, mis);
        end
        if_done = 1'b1; if_ce_i = 1'b0;
      end
    end
    if (!(if_done && mem_done)) begin
      total++; bad++;
      $display("FAIL %s timeout: got if_done=%b mem_done=%b want 1 1", tag, if_done, mem_done);
      if_ce_i = 1'b0; mem_ce_i = 1'b0;
      step(); step();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o, if_ready_o,
         mem_ready_o, if_data_o, mem_data_o, align_exc_o, stall_req_o} !== '0) begin
      bad++;
      $display("FAIL reset: got ce=%b addr=%h sel=%b mr=%b ir=%b want all 0",
               ram_ce_o, ram_addr_o, ram_sel_o, mem_ready_o, if_ready_o);
    end
  endtask

  task automatic test_word_load();
    int c;
    ram_mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
    fixed_lat = 3;
    run_req(0, 0, 1, 0, 32'h10, 2'b10, 0, 0, 0, "word_load", c);
    total++;
    if (c !== 5 || mem_data_o !== 32'h8899_AABB) begin
      bad++;
      $display("FAIL word_load: got cyc=%0d data=%h want cyc=5 data=8899aabb", c, mem_data_o);
    end
    total++;
    if (iss_addr !== 32'h10 || iss_sel !== 4'b1111 || iss_we !== 1'b0) begin
      bad++;
      $display("FAIL word_load_issue: got addr=%h sel=%b we=%b want 10 1111 0",
               iss_addr, iss_sel, iss_we);
    end
    fixed_lat = -1;
  endtask

  task automatic test_byte_load();
    int c;
    run_req(0, 0, 1, 0, 32'h13, 2'b00, 1, 0, 0, "byte_signed", c);
    total++;
    if (mem_data_o !== 32'hFFFF_FF88) begin
      bad++; $display("FAIL byte_signed: got %h want ffffff88", mem_data_o);
    end
    run_req(0, 0, 1, 0, 32'h13, 2'b00, 0, 0, 0, "byte_unsigned", c);
    total++;
    if (mem_data_o !== 32'h0000_0088) begin
      bad++; $display("FAIL byte_unsigned: got %h want 00000088", mem_data_o);
    end
  endtask

  task automatic test_half_store();
    int c;
    run_req(0, 0, 1, 1, 32'h22, 2'b01, 0, 32'hDEAD_1234, 0, "half_store", c);
    total++;
    if (iss_we !== 1'b1 || iss_sel !== 4'b1100 || iss_addr !== 32'h20 ||
        iss_data !== 32'h1234_1234 || mem_data_o !== 32'd0) begin
      bad++;
      $display("FAIL half_store: got we=%b sel=%b addr=%h data=%h rd=%h want 1 1100 20 12341234 0",
               iss_we, iss_sel, iss_addr, iss_data, mem_data_o);
    end
    run_req(0, 0, 1, 0, 32'h20, 2'b10, 0, 0, 0, "half_readback", c);
  endtask

  task automatic test_arbitration();
    int c, n0;
    n0 = issue_cnt;
    run_req(1, 32'h8, 1, 0, 32'h10, 2'b10, 0, 0, 1, "arb", c);
    total++;
    if (issue_cnt - n0 !== 2 || stall_req_o !== 1'b0) begin
      bad++;
      $display("FAIL arb_end: got issues=%0d stall=%b want 2 0", issue_cnt - n0, stall_req_o);
    end
  endtask

  task automatic test_abort();
    bit seen_ready, was_on;
    fixed_lat = 6; seen_ready = 1'b0;
    if_addr_i = 32'h4; if_ce_i = 1'b1;
    step(); step();
    was_on = ram_ce_o;
    if_ce_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_ready_o) seen_ready = 1'b1;
    end
    total++;
    if (was_on !== 1'b1 || seen_ready !== 1'b0 || ram_ce_o !== 1'b0) begin
      bad++;
      $display("FAIL abort: got was_on=%b ready_seen=%b ce=%b want 1 0 0",
               was_on, seen_ready, ram_ce_o);
    end
    fixed_lat = -1;
  endtask

  task automatic test_reset_mid();
    int c;
    bit seen_ready;
    fixed_lat = 8; seen_ready = 1'b0;
    mem_we_i = 1'b0; mem_addr_i = 32'h10; mem_size_i = 2'b10; mem_ce_i = 1'b1;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o, if_ready_o,
         mem_ready_o, if_data_o, mem_data_o, align_exc_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got ce=%b addr=%h sel=%b mr=%b want all 0",
               ram_ce_o, ram_addr_o, ram_sel_o, mem_ready_o);
    end
    mem_ce_i = 1'b0; ram_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    prev_ce = 1'b0; seen_issue = 1'b0; ce_low_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_ready_o || ram_ce_o) seen_ready = 1'b1;
    end
    total++;
    if (seen_ready !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet: got activity=1 want 0");
    end
    fixed_lat = -1;
    run_req(0, 0, 1, 0, 32'h14, 2'b10, 0, 0, 0, "after_reset", c);
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    int c, n0;
    n0 = issue_cnt;
    run_req(0, 0, 1, 0, 32'h6, 2'b10, 0, 0, 0, "align", c);
    total++;
    if (issue_cnt !== n0 || mem_data_o !== 32'd0) begin
      bad++;
      $display("FAIL align: got issues=%0d data=%h want 0 0", issue_cnt - n0, mem_data_o);
    end
`endif
  endtask

  task automatic test_random();
    int c, kind;
    for (int t = 0; t < 150; t++) begin
      kind = int'($urandom_range(0, 2));
      run_req(kind != 0, 32'($urandom_range(0, 63)),
              kind != 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
              0, "random", c);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    mem_size_i = 2'b00; mem_signed_i = 1'b0;
    ram_ready_i = 1'b0; ram_data_i = '0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom();
      ref_mem[i] = ram_mem[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_arbitration();
    test_abort();
    test_reset_mid();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
